seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It shares one 4-bit-to-7-segment decoder across all digits. Each digit's nibble is presented to the decoder in turn while the matching anode is driven, with a blanking gap between digits to suppress ghosting. It sits between the register/CPU side, which writes a packed hex value through a valid/ready handshake, and the decoder plus the board anode pins.

## Interface
Parameters:
- NUM_DIGITS, 4: digits scanned, legal range 2..8.
- DWELL_CYCLES, 1000: cycles each digit is lit, must be ≥1.
- BLANK_CYCLES, 16: cycles all anodes are off before each digit, must be ≥1.

Ports:
- clk  in  1  system clock. One clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  scan enable.
- wr_valid  in  1  write request.
- wr_ready  out  1  controller can accept a write.
- wr_data  in  4*NUM_DIGITS  packed digits. Digit i = wr_data[4i+3:4i]. Digit 0 is least significant.
- digit_code  out  4  nibble to the shared decoder.
- an_n  out  NUM_DIGITS  anode enables, active-low. an_n[i] drives digit i.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Registers:
  - active (displayed value)
  - pending plus pend_full flag
  - idx (current digit)
  - cnt (phase counter)
  - state
- Write handshake:
  - wr_ready = !pend_full.
  - On wr_valid && wr_ready, pending ← wr_data and pend_full ← 1.
  - The write is accepted once per handshake. A second write is stalled until transfer.
- Transfer: active ← pending and pend_full ← 0 at a frame boundary. A frame boundary is either the last DRIVE cycle of digit NUM_DIGITS-1, or any cycle in IDLE.
- The displayed value never changes mid-frame.
- States:
  - IDLE:
    - an_n all 1, digit_code 0, idx 0, cnt 0.
    - en=1 → BLANK.
  - BLANK:
    - an_n all 1, digit_code = active digit idx.
    - After BLANK_CYCLES cycles → DRIVE.
  - DRIVE:
    - an_n[idx]=0, all other bits 1; digit_code = active digit idx.
    - After DWELL_CYCLES cycles → BLANK with idx+1.
    - If idx=NUM_DIGITS-1, idx wraps to 0 and frame_done pulses.
- en=0 in any state → IDLE on the next edge. idx and cnt are cleared. A partial frame gives no frame_done.
- Re-enable always restarts at digit 0 with BLANK.
- cnt width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1). cnt resets to 0 at each phase change.

## Timing
- All outputs are registered.
- Reset values:
  - an_n all 1
  - digit_code 0
  - frame_done 0
  - wr_ready 1
  - active 0, pend_full 0, state IDLE
- Reset mid-frame discards pending and active data.
- Frame length is NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- frame_done is high in the first BLANK cycle of the next frame.
- wr_ready rises in that same cycle, one cycle after the transfer edge.
- A write accepted while in IDLE is visible at the first BLANK after en rises. If en is already high, it is visible from the next frame.
- wr_ready is low during the transfer cycle, so there is no collision between a new write and the transfer.

## Configuration
- LEADING_ZERO_BLANK_EN, when defined: in DRIVE for digit i>0, an_n stays all 1 if active digits NUM_DIGITS-1 down to i are all zero. Digit 0 is always lit. Phase timing and frame_done are unchanged.
- When undefined, every digit is lit, including leading zeros.

## Structure
- seg_scan_pkg holds:
  - the state enum: IDLE, BLANK, DRIVE
  - a digit-extract function
  - the default parameter constants
- Sub-module seg_phase_timer: a loadable down/up counter that asserts a terminal flag at a programmed count. Two instances, or one shared instance muxed by state.
- The decoder itself is instantiated outside the block. It is fed by digit_code.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset: rst_n low 3 cycles → an_n=4'b1111, digit_code=0, wr_ready=1, frame_done=0.
- Basic scan: write 16'h1234 with en=0, then en=1.
  - Cycles 1-2: an_n=1111, digit_code=4.
  - Cycles 3-6: an_n=1110, digit_code=4.
  - Next digit: digit_code=3 with an_n=1101; then 2/1011; then 1/0111.
  - frame_done pulses on cycle 25.
- Mid-frame update: during digit 1, write 16'hABCD.
  - wr_ready=0 until the frame boundary; 1234 is still shown.
  - The next frame shows D, C, B, A.
  - wr_ready returns to 1 together with frame_done.
- Enable drop: en=0 during DRIVE of digit 2 → next cycle an_n=1111. Re-enable → BLANK with digit 0 and no frame_done.
- Reset mid-frame: rst_n low during DRIVE → all outputs at reset values; pending write lost.
- With LEADING_ZERO_BLANK_EN:
  - 16'h0045 → an_n stays 1111 during DRIVE of digits 3 and 2.
  - 16'h0000 → only an_n[0] goes low, with digit_code=0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and defaults for the 7-segment scan controller.
// Optional feature macro: LEADING_ZERO_BLANK_EN (used in seg_scan_ctrl).
package seg_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } seg_state_e;

   localparam int DEF_NUM_DIGITS   = 4;
   localparam int DEF_DWELL_CYCLES = 1000;
   localparam int DEF_BLANK_CYCLES = 16;

   // Nibble idx of a packed hex value (digit 0 in bits [3:0]).
   function automatic logic [3:0] get_digit(input logic [31:0] val, input logic [31:0] idx);
      logic [31:0] sh;
      sh = val >> (32'd4 * idx);
      return sh[3:0];
   endfunction

endpackage

// File: rtl/seg_phase_timer.sv
// Phase counter: counts up from zero, flags when the programmed terminal count is reached.
module seg_phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [W-1:0] tc,
   output logic         done
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clr ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done = (cnt_q == tc);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Define LEADING_ZERO_BLANK_EN to keep leading-zero digits dark.
//
// state    | meaning
// ST_IDLE  | scan stopped, anodes off, frame boundary every cycle
// ST_BLANK | anodes off ahead of digit idx (anti-ghosting gap)
// ST_DRIVE | anode idx lit with its nibble on digit_code
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
   parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   output logic [3:0]              digit_code,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int DW    = 4 * NUM_DIGITS;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int MAXC  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W = $clog2(MAXC + 1);
   localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   seg_state_e            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DW-1:0]         active_q, active_d;
   logic [DW-1:0]         pending_q, pending_d;
   logic                  pend_full_q, pend_full_d;
   logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
   logic [3:0]            digit_code_q, digit_code_d;
   logic                  frame_done_q, frame_done_d;

   logic                  boundary;
   logic                  lit;
   logic [31:0]           act_ext;
   logic                  tmr_clr;
   logic                  tmr_done;
   logic [CNT_W-1:0]      tmr_tc;

   seg_phase_timer #(.W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .tc    (tmr_tc),
      .done  (tmr_done)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      active_d     = active_q;
      pending_d    = pending_q;
      pend_full_d  = pend_full_q;
      frame_done_d = 1'b0;
      boundary     = 1'b0;
      tmr_tc       = (state_q == ST_DRIVE) ? DWELL_TC : BLANK_TC;

      case (state_q)
         ST_IDLE: begin
            idx_d    = '0;
            boundary = 1'b1;
            if (en) state_d = ST_BLANK;
         end
         ST_BLANK: begin
            if (tmr_done) state_d = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (tmr_done) begin
               state_d = ST_BLANK;
               if (idx_q == LAST_IDX) begin
                  idx_d        = '0;
                  boundary     = 1'b1;
                  frame_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Dropping enable abandons the frame without a frame_done.
      if (!en) begin
         state_d      = ST_IDLE;
         idx_d        = '0;
         frame_done_d = 1'b0;
      end

      // wr_ready is low whenever a transfer can happen, so these never collide.
      if (boundary && pend_full_q) begin
         active_d    = pending_q;
         pend_full_d = 1'b0;
      end
      if (wr_valid && !pend_full_q) begin
         pending_d   = wr_data;
         pend_full_d = 1'b1;
      end

      tmr_clr = (state_d != state_q) || (state_q == ST_IDLE);

      // Outputs are registered from next-state values so they line up with state_q.
      act_ext = 32'(active_d);
`ifdef LEADING_ZERO_BLANK_EN
      lit = (idx_d == '0) || ((act_ext >> (32'd4 * 32'(idx_d))) != 32'd0);
`else
      lit = 1'b1;
`endif
      digit_code_d = 4'h0;
      an_n_d       = '1;
      if (state_d != ST_IDLE) digit_code_d = get_digit(act_ext, 32'(idx_d));
      if (state_d == ST_DRIVE && lit) an_n_d = ~(NUM_DIGITS'(1) << idx_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         active_q     <= '0;
         pending_q    <= '0;
         pend_full_q  <= 1'b0;
         an_n_q       <= '1;
         digit_code_q <= 4'h0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         pend_full_q  <= pend_full_d;
         an_n_q       <= an_n_d;
         digit_code_q <= digit_code_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wr_ready   = ~pend_full_q;
   assign an_n       = an_n_q;
   assign digit_code = digit_code_q;
   assign frame_done = frame_done_q;

endmodule
